// File: rtl/wordop_rr_scheduler.sv
// Round-robin scheduler sharing one registered bitwise word unit between NREQ requesters.
// Accept in IDLE, compute in EXEC, hold the tagged result in HOLD until the sink takes it.
module wordop_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [W*NREQ-1:0]    req_a,
  input  logic [W*NREQ-1:0]    req_b,
  input  logic [W*NREQ-1:0]    req_c,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W-1:0]         res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q, c_q;

  logic [2*NREQ-1:0] valid_rot;
  logic              grant_any;
  logic [IDW-1:0]    grant_idx;
  logic [2:0]        sel_op;
  logic [W-1:0]      sel_a, sel_b, sel_c;

  // Index addition modulo NREQ; one spare bit keeps the carry for non-power-of-two NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    logic [IDW:0] s;
    s = {1'b0, base} + (IDW+1)'(off);
    if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
    return s[IDW-1:0];
  endfunction

  function automatic logic [W-1:0] word_op(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~a;
      3'd5:    return a & ~b;
      3'd6:    return (a & c) | (b & ~c);
      default: return ((a & b) ^ c) | ((~a & ~b) ~^ c);
    endcase
  endfunction

  // Rotating the doubled valid vector by rr_ptr puts the highest-priority requester at bit 0;
  // scanning downwards lets the lowest set offset win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_any = 1'b0;
    grant_idx = '0;
    valid_rot = {req_valid, req_valid} >> rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_any = 1'b1;
        grant_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_c     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        req_ready[i] = (state == S_IDLE) && grant_any;
        sel_op       = req_op[3*i +: 3];
        sel_a        = req_a[W*i +: W];
        sel_b        = req_b[W*i +: W];
        sel_c        = req_c[W*i +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state     <= S_IDLE;
      rr_ptr    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      busy      <= 1'b0;
      done_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            c_q    <= sel_c;
            res_id <= grant_idx;
            rr_ptr <= wrap_add(grant_idx, 1);
            busy   <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data  <= word_op(op_q, a_q, b_q, c_q);
          res_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wordop_rr_scheduler.sv
// Directed bench for wordop_rr_scheduler: a transaction-level model is compared against the DUT
// on every falling edge, plus hand-computed literal expectations for each scenario.
module tb_wordop_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_op = '0;
  logic [W*NREQ-1:0]    req_a = '0, req_b = '0, req_c = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [W-1:0]         res_data;
  logic [IDW-1:0]       res_id;
  logic                 busy;
  logic [15:0]          done_cnt;

  wordop_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request is granted, its result appears one cycle later and is
  // held until the sink takes it. Stage 0 = free, 1 = computing, 2 = result offered.
  bit             m_live = 1'b0;
  int             m_stage = 0;
  int             m_rr = 0;
  int             m_id = 0;
  int             m_cnt = 0;
  logic [W-1:0]   m_data = '0;
  logic [W-1:0]   m_pend = '0;

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (op)
        3'd0: r[i] = a[i] && b[i];
        3'd1: r[i] = a[i] || b[i];
        3'd2: r[i] = a[i] != b[i];
        3'd3: r[i] = a[i] == b[i];
        3'd4: r[i] = !a[i];
        3'd5: r[i] = a[i] && !b[i];
        3'd6: r[i] = c[i] ? a[i] : b[i];
        default: r[i] = ((a[i] && b[i]) != c[i]) || ((!a[i] && !b[i]) == c[i]);
      endcase
    end
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int g;
    g = pick(req_valid, m_rr);
    exp_ready = '0;
    if (m_stage == 0 && g >= 0) exp_ready[g] = 1'b1;
    if (m_live) begin
      check("req_ready", req_ready, exp_ready);
      check("res_valid", res_valid, m_stage == 2);
      check("busy", busy, m_stage != 0);
      check("res_data", res_data, m_data);
      check("res_id", res_id, m_id);
      check("done_cnt", done_cnt, m_cnt);
    end
    if (!rst) begin
      m_live = 1'b1; m_stage = 0; m_rr = 0; m_id = 0; m_cnt = 0; m_data = '0; m_pend = '0;
    end else if (m_live) begin
      case (m_stage)
        0: if (g >= 0) begin
          m_pend  = ref_op(req_op[3*g +: 3], req_a[W*g +: W], req_b[W*g +: W], req_c[W*g +: W]);
          m_id    = g;
          m_rr    = (g + 1) % NREQ;
          m_stage = 1;
        end
        1: begin m_data = m_pend; m_stage = 2; end
        default: if (res_ready) begin m_cnt = (m_cnt + 1) & 16'hFFFF; m_stage = 0; end
      endcase
    end
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c);
    req_valid[i]     = 1'b1;
    req_op[3*i +: 3] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
    req_c[W*i +: W]  = c;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; res_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic wait_ready(input int i, input string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 20) begin @(negedge clk); n++; end
    check(name, req_ready[i], 1'b1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    check(name, res_valid, 1'b1);
  endtask

  task automatic run_one(input int i, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         output logic [W-1:0] d, output logic [IDW-1:0] id);
    set_req(i, op, a, b, c);
    res_ready = 1'b1;
    wait_ready(i, "run_grant");
    @(posedge clk); #1 req_valid[i] = 1'b0;
    wait_valid("run_result");
    d  = res_data;
    id = res_id;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   d;
    logic [IDW-1:0] id;
    logic [7:0]     sweep_exp [7];
    int             seq [$];
    int             n;
    sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h0F, 8'h30, 8'hE4};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_cnt", done_cnt, 16'd0);
    check("rst_res_data", res_data, 8'h00);
    check("rst_req_ready", req_ready, 4'b0000);
    @(posedge clk); #1;

    // Single request from requester 2, opcode 7
    set_req(2, 3'd7, 8'h0F, 8'h33, 8'h55);
    res_ready = 1'b1;
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    @(negedge clk);
    check("t1_exec_valid", res_valid, 1'b0);
    check("t1_exec_busy", busy, 1'b1);
    @(negedge clk);
    check("t1_valid", res_valid, 1'b1);
    check("t1_data", res_data, 8'h7E);
    check("t1_id", res_id, 2'd2);
    @(negedge clk);
    check("t1_done", done_cnt, 16'd1);
    check("t1_released", res_valid, 1'b0);
    @(posedge clk); #1;

    // Opcode sweep on requester 0
    for (int op = 0; op < 7; op++) begin
      run_one(0, 3'(op), 8'hF0, 8'hCC, 8'hAA, d, id);
      check("sweep_data", d, sweep_exp[op]);
      check("sweep_id", id, 2'd0);
    end
    @(negedge clk);
    check("sweep_done_cnt", done_cnt, 16'd8);
    @(posedge clk); #1;

    // Fairness: all requesters continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 8'h5A, 8'h3C, 8'hF0);
    res_ready = 1'b1;
    n = 0;
    while (seq.size() < 12 && n < 200) begin
      @(negedge clk);
      if (res_valid) seq.push_back(int'(res_id));
      n++;
    end
    @(posedge clk); #1 req_valid = '0;
    check("fair_count", seq.size(), 12);
    for (int k = 0; k < seq.size(); k++) check("fair_order", seq[k], k % NREQ);
    @(negedge clk);
    check("fair_done_cnt", done_cnt, 16'd12);
    @(posedge clk); #1;

    // Reset during EXEC
    set_req(2, 3'd1, 8'h01, 8'h02, 8'h00);
    res_ready = 1'b0;
    @(negedge clk);
    check("rx_ready", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid[2] = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rx_exec_busy", busy, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rx_valid", res_valid, 1'b0);
    check("rx_busy", busy, 1'b0);
    check("rx_done_cnt", done_cnt, 16'd0);
    @(posedge clk); #1;
    set_req(1, 3'd2, 8'hFF, 8'h0F, 8'h00);
    set_req(3, 3'd4, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    check("rx_first_grant", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rh_hold_valid", res_valid, 1'b1);
    check("rh_hold_data", res_data, 8'hF0);
    check("rh_hold_id", res_id, 2'd1);
    // Reset during HOLD
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1; req_valid = '0;
    @(negedge clk);
    check("rh_valid", res_valid, 1'b0);
    check("rh_busy", busy, 1'b0);
    check("rh_done_cnt", done_cnt, 16'd0);
    check("rh_id", res_id, 2'd0);
    @(posedge clk); #1;
    set_req(2, 3'd0, 8'hFF, 8'hFF, 8'h00);
    set_req(3, 3'd0, 8'hFF, 8'hFF, 8'h00);
    @(negedge clk);
    check("rh_first_grant", req_ready, 4'b0100);

    // Back-pressure
    do_reset();
    set_req(1, 3'd2, 8'h5A, 8'hFF, 8'h00);
    set_req(3, 3'd0, 8'hFF, 8'h0F, 8'h00);
    res_ready = 1'b0;
    wait_ready(1, "bp_grant");
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_valid("bp_result");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", res_valid, 1'b1);
      check("bp_data", res_data, 8'hA5);
      check("bp_id", res_id, 2'd1);
      check("bp_ready", req_ready, 4'b0000);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    check("bp_release_valid", res_valid, 1'b0);
    check("bp_release_busy", busy, 1'b0);
    check("bp_release_cnt", done_cnt, 16'd1);
    check("bp_next_grant", req_ready, 4'b1000);
    @(posedge clk); #1 req_valid = '0; res_ready = 1'b1;
    wait_valid("bp_second_result");
    check("bp_second_data", res_data, 8'h0F);
    check("bp_second_id", res_id, 2'd3);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
